// File: rtl/apb_ctrl_pkg.sv
// Shared types and helpers for the APB master arbiter slice:
// transfer FSM state type, default bus widths and the round-robin
// slot helper used by the arbiter.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    // Requester index examined at position 'offset' of a rotation that
    // starts just after 'last'. Both inputs are below n, so the sum is at
    // most 2n-1 and a single conditional subtract replaces a modulo.
    function automatic int unsigned rr_slot(input int unsigned last,
                                            input int unsigned offset,
                                            input int unsigned n);
        int unsigned s;
        s = last + 32'd1 + offset;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin arbiter. Scans the request vector starting
// one position after last_grant and grants the first active requester.
// Produces both a one-hot grant and the grant index; all zero when
// disabled or when nobody is requesting.
module apb_rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Rotating priority scan; the first hit after last_grant wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'(rr_slot(32'(last_grant), k, NUM_REQ));
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master port shared by NUM_REQ local requesters.
// Round-robin arbitration in IDLE, then a SETUP/ACCESS sequence for the
// granted requester; the completion pulse, read data and slave error are
// returned to that requester only.
// Optional build macro APB_TIMEOUT_EN: bounds the ACCESS phase to
// TIMEOUT_CYCLES wait cycles and then completes with an error.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    output logic                      pwrite,
    output logic                      pselx,
    output logic                      penable,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslave_error
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_e       state_q;
    apb_state_e       state_d;
    logic [IDX_W-1:0] last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             arb_en;
    logic             accept;
    logic             complete;
    logic             timeout;

    assign arb_en   = (state_q == IDLE);
    assign accept   = arb_en && (|grant);
    assign complete = (state_q == ACCESS) && pready;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count ACCESS cycles without pready; held at zero outside ACCESS so
    // every transfer enters ACCESS with a cleared counter.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (state_q != ACCESS) begin
            wait_cnt <= '0;
        end else if (!pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the last permitted wait cycle; pready in that same cycle
    // takes the normal completion path instead.
    assign timeout = (state_q == ACCESS) && !pready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SETUP on a grant, SETUP is a single
    // cycle, ACCESS ends on pready (or on the wait limit when enabled).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (complete || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: select/enable come straight from the state so an
    // asynchronous reset drops them immediately.
    always_comb begin
        req_ready = '0;
        pselx     = 1'b0;
        penable   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
            end
            SETUP: begin
                pselx = 1'b1;
            end
            ACCESS: begin
                pselx   = 1'b1;
                penable = 1'b1;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    // Capture the granted request and advance the rotation pointer; the
    // address, data and direction hold their values after the transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr      <= '0;
            pwdata     <= '0;
            pwrite     <= 1'b0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (accept) begin
            paddr      <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            pwdata     <= req_wdata[grant_idx*DATA_W +: DATA_W];
            pwrite     <= req_write[grant_idx];
            last_grant <= grant_idx;
        end
    end

    // One-cycle completion pulse to the current grantee; read data is
    // forced to zero for writes and for wait-limit terminations.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (complete) begin
                rsp_valid <= NUM_REQ'(1) << last_grant;
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslave_error;
            end else if (timeout) begin
                rsp_valid <= NUM_REQ'(1) << last_grant;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Testbench for apb_master_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin/APB model.
module tb_apb_master_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic              pselx;
    logic              penable;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslave_error;

    logic [AW-1:0]     a_addr  [NR];
    logic [DW-1:0]     a_wdata [NR];

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = a_addr[i];
            req_wdata[i*DW +: DW] = a_wdata[i];
        end
    end

    apb_master_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pwrite       (pwrite),
        .pselx        (pselx),
        .penable      (penable),
        .prdata       (prdata),
        .pready       (pready),
        .pslave_error (pslave_error)
    );

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset;
        presetn      = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        pready       = 1'b0;
        prdata       = '0;
        pslave_error = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a_addr[i]  = '0;
            a_wdata[i] = '0;
        end
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
    endtask

    // Drives one request from requester idx and acts as an APB slave that
    // inserts 'waits' low-pready ACCESS cycles; reports what it observed.
    task automatic run_one(input int idx, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input int waits,
                           input logic [DW-1:0] rd, input logic err,
                           output logic [NR-1:0] rdy, output int sel_n, output int en_n,
                           output int rsp_n, output logic [NR-1:0] rv,
                           output logic [DW-1:0] rdat, output logic re,
                           output logic [AW-1:0] pa, output logic pw,
                           output logic [DW-1:0] pd);
        int w;
        int after;
        sel_n = 0; en_n = 0; rsp_n = 0; rv = '0; rdat = '0; re = 1'b0;
        pa = '0; pw = 1'b0; pd = '0; w = 0; after = -1;
        @(negedge pclk);
        a_addr[idx]    = addr;
        a_wdata[idx]   = wd;
        req_write[idx] = wr;
        req_valid      = oh(idx);
        pready         = 1'b0;
        #1 rdy = req_ready;
        for (int c = 0; c < 60 && after < 2; c++) begin
            @(negedge pclk);
            req_valid = '0;
            if (pselx) begin
                if (sel_n == 0) begin
                    pa = paddr; pw = pwrite; pd = pwdata;
                end
                sel_n++;
            end
            if (penable) en_n++;
            if (rsp_valid !== '0) begin
                rsp_n++;
                rv = rsp_valid; rdat = rsp_rdata; re = rsp_err;
                if (after < 0) after = 0;
            end
            if (after >= 0) after++;
            if (penable) begin
                if (w >= waits) begin
                    pready = 1'b1; prdata = rd; pslave_error = err;
                end else begin
                    pready = 1'b0; prdata = ~rd; pslave_error = ~err; w++;
                end
            end else begin
                pready = 1'b0; prdata = '0; pslave_error = 1'b0;
            end
        end
        pready = 1'b0;
    endtask

    task automatic test_reset;
        presetn      = 1'b0;
        req_valid    = '0;
        req_write    = '0;
        pready       = 1'b0;
        prdata       = '0;
        pslave_error = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a_addr[i] = '0; a_wdata[i] = '0;
        end
        #3;
        checks++;
        if ({pselx, penable, pwrite, rsp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got sel/en/wr/err=%b exp 0000", {pselx, penable, pwrite, rsp_err});
        end
        checks++;
        if ({req_ready, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_vec got ready=%b rsp_valid=%b exp 0", req_ready, rsp_valid);
        end
        checks++;
        if ({paddr, pwdata, rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp 0", paddr, pwdata, rsp_rdata);
        end
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
    endtask

    task automatic test_single_write;
        logic [NR-1:0] rdy, rv; int sel_n, en_n, rsp_n;
        logic [DW-1:0] rdat, pd; logic re, pw; logic [AW-1:0] pa;
        run_one(0, 1'b1, 32'h10, 32'hA5A5_0001, 0, 32'h1234_5678, 1'b0,
                rdy, sel_n, en_n, rsp_n, rv, rdat, re, pa, pw, pd);
        checks++;
        if (rdy !== 4'b0001) begin
            errors++; $display("FAIL sw_ready got %b exp 0001", rdy);
        end
        checks++;
        if (sel_n != 2 || en_n != 1) begin
            errors++; $display("FAIL sw_phases got sel=%0d en=%0d exp sel=2 en=1", sel_n, en_n);
        end
        checks++;
        if ({pa, pw, pd} !== {32'h10, 1'b1, 32'hA5A5_0001}) begin
            errors++; $display("FAIL sw_bus got addr=%h wr=%b data=%h exp 10/1/a5a50001", pa, pw, pd);
        end
        checks++;
        if (rsp_n != 1 || rv !== 4'b0001 || re !== 1'b0 || rdat !== '0) begin
            errors++;
            $display("FAIL sw_rsp got n=%0d v=%b err=%b rdata=%h exp 1/0001/0/0", rsp_n, rv, re, rdat);
        end
    endtask

    task automatic test_read_wait;
        logic [NR-1:0] rdy, rv; int sel_n, en_n, rsp_n;
        logic [DW-1:0] rdat, pd; logic re, pw; logic [AW-1:0] pa;
        run_one(2, 1'b0, 32'h20, 32'h0, 3, 32'hDEAD_BEEF, 1'b0,
                rdy, sel_n, en_n, rsp_n, rv, rdat, re, pa, pw, pd);
        checks++;
        if (rdy !== 4'b0100) begin
            errors++; $display("FAIL rd_ready got %b exp 0100", rdy);
        end
        checks++;
        if (sel_n != 5 || en_n != 4) begin
            errors++; $display("FAIL rd_phases got sel=%0d en=%0d exp sel=5 en=4", sel_n, en_n);
        end
        checks++;
        if (pa !== 32'h20 || pw !== 1'b0) begin
            errors++; $display("FAIL rd_bus got addr=%h wr=%b exp 20/0", pa, pw);
        end
        checks++;
        if (rsp_n != 1 || rv !== 4'b0100 || re !== 1'b0 || rdat !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rd_rsp got n=%0d v=%b err=%b rdata=%h exp 1/0100/0/deadbeef", rsp_n, rv, re, rdat);
        end
    endtask

    task automatic test_slave_error;
        logic [NR-1:0] rdy, rv; int sel_n, en_n, rsp_n;
        logic [DW-1:0] rdat, pd; logic re, pw; logic [AW-1:0] pa;
        run_one(1, 1'b1, 32'h30, 32'h0BAD_0BAD, 1, 32'h7777_7777, 1'b1,
                rdy, sel_n, en_n, rsp_n, rv, rdat, re, pa, pw, pd);
        checks++;
        if (rsp_n != 1 || rv !== 4'b0010 || re !== 1'b1 || rdat !== '0) begin
            errors++;
            $display("FAIL err_rsp got n=%0d v=%b err=%b rdata=%h exp 1/0010/1/0", rsp_n, rv, re, rdat);
        end
        run_one(3, 1'b0, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 1'b0,
                rdy, sel_n, en_n, rsp_n, rv, rdat, re, pa, pw, pd);
        checks++;
        if (rdy !== 4'b1000 || rsp_n != 1 || rv !== 4'b1000 || re !== 1'b0 || rdat !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL err_next got rdy=%b n=%0d v=%b err=%b rdata=%h exp 1000/1/1000/0/cafef00d",
                     rdy, rsp_n, rv, re, rdat);
        end
    endtask

    task automatic test_contention;
        int n_gr;
        int n_rsp;
        int gq[$];
        int g;
        do_reset;
        n_gr = 0; n_rsp = 0;
        @(negedge pclk);
        for (int i = 0; i < NR; i++) begin
            a_addr[i] = 32'h100 + 32'(i) * 4; a_wdata[i] = 32'(i); req_write[i] = 1'(i);
        end
        req_valid = '1;
        for (int c = 0; c < 80 && n_rsp < 5; c++) begin
            if (c > 0) @(negedge pclk);
            if (rsp_valid !== '0) begin
                g = (gq.size() > 0) ? gq.pop_front() : 0;
                checks++;
                if (rsp_valid !== oh(g)) begin
                    errors++; $display("FAIL cont_rsp%0d got %b exp %b", n_rsp, rsp_valid, oh(g));
                end
                n_rsp++;
            end
            pready = penable;
            prdata = $urandom;
            pslave_error = 1'b0;
            #1;
            if (req_ready !== '0) begin
                checks++;
                if (req_ready !== oh(n_gr % NR)) begin
                    errors++; $display("FAIL cont_grant%0d got %b exp %b", n_gr, req_ready, oh(n_gr % NR));
                end
                gq.push_back(n_gr % NR);
                n_gr++;
            end
        end
        checks++;
        if (n_rsp != 5) begin
            errors++; $display("FAIL cont_count got %0d responses exp 5", n_rsp);
        end
        req_valid = '0;
        pready = 1'b0;
    endtask

    task automatic test_random;
        logic          pend [NR];
        logic          busy, rsp_due, done_now, cur_w, exp_er;
        logic [AW-1:0] cur_a;
        logic [DW-1:0] cur_d, exp_rd;
        logic [NR-1:0] exp_rdy;
        int            mlast, cur, waits_left, exp_w, sel_n, en_n, g, idx, n_done;
        do_reset;
        mlast = NR - 1; busy = 1'b0; rsp_due = 1'b0; cur = 0; cur_w = 1'b0;
        cur_a = '0; cur_d = '0; exp_rd = '0; exp_er = 1'b0;
        waits_left = 0; exp_w = 0; sel_n = 0; en_n = 0; n_done = 0;
        for (int i = 0; i < NR; i++) pend[i] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge pclk);
            checks++;
            if (rsp_due) begin
                if (rsp_valid !== oh(cur) || rsp_rdata !== exp_rd || rsp_err !== exp_er ||
                    sel_n != exp_w + 2 || en_n != exp_w + 1) begin
                    errors++;
                    $display("FAIL rnd_rsp c=%0d got v=%b d=%h e=%b sel=%0d en=%0d exp v=%b d=%h e=%b sel=%0d en=%0d",
                             c, rsp_valid, rsp_rdata, rsp_err, sel_n, en_n, oh(cur), exp_rd, exp_er, exp_w + 2, exp_w + 1);
                end
                n_done++;
            end else if (rsp_valid !== '0) begin
                errors++; $display("FAIL rnd_spurious c=%0d got rsp_valid=%b exp 0", c, rsp_valid);
            end
            rsp_due = 1'b0;
            checks++;
            if (busy) begin
                if (pselx) sel_n++;
                if (penable) en_n++;
                if (pselx !== 1'b1 || paddr !== cur_a || pwrite !== cur_w || pwdata !== cur_d) begin
                    errors++;
                    $display("FAIL rnd_bus c=%0d got sel=%b a=%h w=%b d=%h exp 1/%h/%b/%h",
                             c, pselx, paddr, pwrite, pwdata, cur_a, cur_w, cur_d);
                end
            end else if (pselx !== 1'b0 || penable !== 1'b0) begin
                errors++; $display("FAIL rnd_idle c=%0d got sel=%b en=%b exp 0/0", c, pselx, penable);
            end
            done_now = 1'b0;
            if (busy && penable) begin
                prdata = $urandom;
                if (waits_left > 0) begin
                    pready = 1'b0; pslave_error = 1'($urandom); waits_left--;
                end else begin
                    pready = 1'b1; pslave_error = 1'($urandom);
                    exp_rd = cur_w ? '0 : prdata; exp_er = pslave_error; done_now = 1'b1;
                end
            end else begin
                pready = 1'($urandom); prdata = $urandom; pslave_error = 1'($urandom);
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i] = 1'b1; req_write[i] = 1'($urandom);
                        a_addr[i] = $urandom; a_wdata[i] = $urandom;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
                req_valid[i] = pend[i];
            end
            #1;
            g = -1;
            if (!busy) begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (mlast + k) % NR;
                    if (g < 0 && pend[idx]) g = idx;
                end
            end
            exp_rdy = (g < 0) ? '0 : oh(g);
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_grant c=%0d got %b exp %b", c, req_ready, exp_rdy);
            end
            if (g >= 0) begin
                busy = 1'b1; mlast = g; cur = g; cur_w = req_write[g];
                cur_a = a_addr[g]; cur_d = a_wdata[g];
                exp_w = $urandom_range(0, 3); waits_left = exp_w;
                sel_n = 0; en_n = 0; pend[g] = 1'b0;
            end
            if (done_now) begin
                busy = 1'b0; rsp_due = 1'b1;
            end
        end
        checks++;
        if (n_done < 20) begin
            errors++; $display("FAIL rnd_progress got %0d completions exp at least 20", n_done);
        end
        req_valid = '0;
        pready = 1'b0;
    endtask

    task automatic test_reset_access;
        do_reset;
        @(negedge pclk);
        a_addr[1] = 32'h50; req_write[1] = 1'b0; req_valid = 4'b0010; pready = 1'b0;
        for (int c = 0; c < 10 && penable !== 1'b1; c++) begin
            @(negedge pclk);
            req_valid = '0;
        end
        checks++;
        if (penable !== 1'b1) begin
            errors++; $display("FAIL rstacc_reach got penable=%b exp 1", penable);
        end
        #2 presetn = 1'b0;
        #1;
        checks++;
        if ({pselx, penable} !== 2'b00) begin
            errors++; $display("FAIL rstacc_async got sel/en=%b exp 00", {pselx, penable});
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== '0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rstacc_norsp got v=%b err=%b exp 0/0", rsp_valid, rsp_err);
        end
        presetn = 1'b1;
        a_addr[0] = 32'h60; a_addr[3] = 32'h6C;
        req_valid = 4'b1011;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL rstacc_prio got %b exp 0001", req_ready);
        end
        @(negedge pclk);
        req_valid = '0;
        checks++;
        if (rsp_valid !== '0 || paddr !== 32'h60) begin
            errors++; $display("FAIL rstacc_after got v=%b addr=%h exp 0/60", rsp_valid, paddr);
        end
        do_reset;
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout;
        logic [NR-1:0] rdy, rv; int sel_n, en_n, rsp_n;
        logic [DW-1:0] rdat, pd; logic re, pw; logic [AW-1:0] pa;
        do_reset;
        run_one(0, 1'b0, 32'h70, 32'h0, 1000, 32'h5555_AAAA, 1'b0,
                rdy, sel_n, en_n, rsp_n, rv, rdat, re, pa, pw, pd);
        checks++;
        if (en_n != TO || sel_n != TO + 1) begin
            errors++; $display("FAIL to_len got en=%0d sel=%0d exp en=%0d sel=%0d", en_n, sel_n, TO, TO + 1);
        end
        checks++;
        if (rsp_n != 1 || rv !== 4'b0001 || re !== 1'b1 || rdat !== '0) begin
            errors++;
            $display("FAIL to_rsp got n=%0d v=%b err=%b rdata=%h exp 1/0001/1/0", rsp_n, rv, re, rdat);
        end
        run_one(1, 1'b0, 32'h74, 32'h0, TO - 1, 32'h1357_9BDF, 1'b0,
                rdy, sel_n, en_n, rsp_n, rv, rdat, re, pa, pw, pd);
        checks++;
        if (rdy !== 4'b0010 || en_n != TO || rsp_n != 1 || re !== 1'b0 || rdat !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL to_edge got rdy=%b en=%0d n=%0d err=%b rdata=%h exp 0010/%0d/1/0/13579bdf",
                     rdy, en_n, rsp_n, re, rdat, TO);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_write;
        test_read_wait;
        test_slave_error;
        test_contention;
        test_random;
        test_reset_access;
`ifdef APB_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
